// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock through a
// WIDTH+1-bit subtractor, with a start/busy/done handshake and registered results.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Div_By_Zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_out_q, quot_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shift_t;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   iter_r;
  logic [WIDTH-1:0] iter_q;

  // One restoring step: a borrow out of the subtract (diff MSB) means keep T.
  always_comb begin
    shift_t = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff    = shift_t - {1'b0, div_q};
    iter_r  = diff[WIDTH] ? shift_t : diff;
    iter_q  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    dbz_d      = dbz_q;

    case (state_q)
      S_IDLE, S_FINISH: begin
        state_d = S_IDLE;
        if (Start) begin
          if (Divisor != '0) begin
            state_d = S_CALC;
            div_d   = Divisor;
            quo_d   = Dividend;
            rem_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end else begin
            state_d    = S_FINISH;
            done_d     = 1'b1;
            quot_out_d = '1;
            rem_out_d  = Dividend;
            dbz_d      = 1'b1;
          end
        end
      end
      S_CALC: begin
        rem_d = iter_r;
        quo_d = iter_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d    = S_FINISH;
          cnt_d      = '0;
          done_d     = 1'b1;
          quot_out_d = iter_q;
          rem_out_d  = iter_r[WIDTH-1:0];
          dbz_d      = 1'b0;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      dbz_q      <= dbz_d;
    end
  end

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Quotient    = quot_out_q;
  assign Remainder   = rem_out_q;
  assign Div_By_Zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=8): directed cases plus
// random operands checked against plain integer division.
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b1;
  logic         Start = 1'b0;
  logic [W-1:0] Dividend = '0;
  logic [W-1:0] Divisor = '0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         Div_By_Zero;

  int n_tests = 0;
  int n_fail  = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start),
    .Dividend(Dividend), .Divisor(Divisor),
    .Busy(Busy), .Done(Done),
    .Quotient(Quotient), .Remainder(Remainder), .Div_By_Zero(Div_By_Zero)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_quot"}, 32'(Quotient), 32'd0);
    chk({tag, "_rem"},  32'(Remainder), 32'd0);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_done"}, 32'(Done), 32'd0);
    chk({tag, "_dbz"},  32'(Div_By_Zero), 32'd0);
  endtask

  // Issue one division and follow it to Done; the expectation is integer
  // division, with the divide-by-zero convention of all ones / dividend.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int eq, er, ez, lat, c, busy_n;
    if (b == 0) begin
      eq = (1 << W) - 1; er = int'(a); ez = 1; lat = 0;
    end else begin
      eq = int'(a) / int'(b); er = int'(a) % int'(b); ez = 0; lat = W;
    end
    Start = 1'b1; Dividend = a; Divisor = b;
    step();
    Start = 1'b0;
    Dividend = W'($urandom);
    Divisor  = W'($urandom);
    c = 0; busy_n = 0;
    while (!Done && c < 40) begin
      busy_n += int'(Busy);
      step();
      c++;
    end
    chk({tag, "_latency"}, 32'(c), 32'(lat));
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(lat));
    chk({tag, "_busy_at_done"}, 32'(Busy), 32'd0);
    chk({tag, "_quot"}, 32'(Quotient), 32'(eq));
    chk({tag, "_rem"}, 32'(Remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(Div_By_Zero), 32'(ez));
    step();
    chk({tag, "_done_pulse"}, 32'(Done), 32'd0);
    chk({tag, "_quot_hold"}, 32'(Quotient), 32'(eq));
    chk({tag, "_rem_hold"}, 32'(Remainder), 32'(er));
  endtask

  initial begin
    int c, ndone;
    logic [W-1:0] ra, rb;

    // Reset held with Start active and random operands
    Rst_n = 1'b0;
    Start = 1'b1;
    Dividend = W'($urandom);
    Divisor  = W'($urandom_range(1, 255));
    #1;
    chk_all_zero("reset_async");
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all_zero("reset_held");
    end
    Start = 1'b0;
    Rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk_all_zero("post_reset_idle");

    run_div(8'd100, 8'd7, "basic_100_7");

    run_div(8'd255, 8'd1, "b_255_1");
    run_div(8'd5, 8'd10, "b_5_10");
    run_div(8'd255, 8'd255, "b_255_255");
    run_div(8'd0, 8'd9, "b_0_9");

    run_div(8'd77, 8'd0, "zero_77_0");
    run_div(8'd9, 8'd3, "after_zero_9_3");

    // Start during CALC is ignored; then back-to-back from FINISH
    Start = 1'b1; Dividend = 8'd200; Divisor = 8'd9;
    step();
    Start = 1'b0;
    step();
    step();
    Start = 1'b1; Dividend = 8'd50; Divisor = 8'd5;
    step();
    Start = 1'b0;
    c = 3;
    while (!Done && c < 40) begin
      step();
      c++;
    end
    chk("calc_start_latency", 32'(c), 32'd8);
    chk("calc_start_quot", 32'(Quotient), 32'd22);
    chk("calc_start_rem", 32'(Remainder), 32'd2);
    Start = 1'b1; Dividend = 8'd50; Divisor = 8'd5;
    step();
    Start = 1'b0;
    c = 1;
    while (!Done && c < 40) begin
      step();
      c++;
    end
    chk("b2b_spacing", 32'(c), 32'd9);
    chk("b2b_quot", 32'(Quotient), 32'd10);
    chk("b2b_rem", 32'(Remainder), 32'd0);
    step();
    chk("b2b_done_pulse", 32'(Done), 32'd0);

    // Reset in the middle of a division
    Start = 1'b1; Dividend = 8'd123; Divisor = 8'd4;
    step();
    Start = 1'b0;
    step();
    step();
    step();
    #2;
    Rst_n = 1'b0;
    #1;
    chk_all_zero("midop_reset");
    step();
    step();
    Rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      ndone += int'(Done);
    end
    chk("midop_no_done", 32'(ndone), 32'd0);
    chk("midop_quot_cleared", 32'(Quotient), 32'd0);
    run_div(8'd123, 8'd4, "after_abort_123_4");

    for (int i = 0; i < 1500; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : W'($urandom_range(1, 255));
      run_div(ra, rb, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
